// File: rtl/preg_free_list_pkg.sv
// preg_free_list_pkg: shared PREG sizing constants and the preg_t index type
package preg_free_list_pkg;
  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int PW = $clog2(NUM_PREGS);
  typedef logic [PW-1:0] preg_t;
endpackage

// File: rtl/preg_free_list_if.sv
// preg_free_list_if: rename/retire <-> free list bundle
//   master (rename/retire side): drives alloc_req, free_valid, free_preg, retire_alloc_cnt, flush
//   slave  (free list):          drives alloc_preg, alloc_empty, free_count, overflow_err
interface preg_free_list_if #(
  parameter int NUM_PREGS = preg_free_list_pkg::NUM_PREGS
);
  localparam int PW = $clog2(NUM_PREGS);
  logic [1:0] alloc_req;
  logic [1:0][PW-1:0] alloc_preg;
  logic [1:0] alloc_empty;
  logic [1:0] free_valid;
  logic [1:0][PW-1:0] free_preg;
  logic [1:0] retire_alloc_cnt;
  logic flush;
  logic [PW:0] free_count;
  logic overflow_err;
  modport master (
    output alloc_req, free_valid, free_preg, retire_alloc_cnt, flush,
    input alloc_preg, alloc_empty, free_count, overflow_err
  );
  modport slave (
    input alloc_req, free_valid, free_preg, retire_alloc_cnt, flush,
    output alloc_preg, alloc_empty, free_count, overflow_err
  );
endinterface

// File: rtl/preg_free_list.sv
// preg_free_list: two-wide circular free list of physical register indices with flush rollback
//   clk : clock
//   rst : asynchronous active-low reset
//   bus : preg_free_list_if.slave (alloc offer/grant, retire frees, flush, status)
module preg_free_list #(
  parameter int NUM_PREGS = preg_free_list_pkg::NUM_PREGS,
  parameter int NUM_AREGS = preg_free_list_pkg::NUM_AREGS
) (
  input logic clk,
  input logic rst,
  preg_free_list_if.slave bus
);
  localparam int PW = $clog2(NUM_PREGS);
  localparam int MAX_FREE = NUM_PREGS - NUM_AREGS;
  typedef logic [PW:0] ptr_t;
  logic [PW-1:0] mem [NUM_PREGS];
  ptr_t head, tail, retire_head, count, head1, tail1, head_n, tail_n, count_n;
  logic g0, g1, ovf_q, ovf_set;
  assign count = tail - head;
  assign head1 = head + ptr_t'(1);
  assign tail1 = tail + ptr_t'(bus.free_valid[0]);
  assign bus.free_count = count;
  assign bus.alloc_empty = {count < ptr_t'(2), count == '0};
  assign bus.alloc_preg[0] = mem[head[PW-1:0]];
  assign bus.alloc_preg[1] = mem[head1[PW-1:0]];
  assign bus.overflow_err = ovf_q;
  always_comb begin
    g0 = bus.alloc_req[0] & ~bus.alloc_empty[0] & ~bus.flush;
    g1 = bus.alloc_req[1] & bus.alloc_req[0] & ~bus.alloc_empty[1] & ~bus.flush;
    head_n = bus.flush ? retire_head + ptr_t'(bus.retire_alloc_cnt) : head + ptr_t'(g0) + ptr_t'(g1);
    tail_n = tail1 + ptr_t'(bus.free_valid[1]);
    count_n = tail_n - head_n;
    ovf_set = |bus.free_valid & (count_n > ptr_t'(MAX_FREE));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      retire_head <= '0;
      tail <= ptr_t'(MAX_FREE);
      ovf_q <= 1'b0;
      for (int i = 0; i < NUM_PREGS; i++) mem[i] <= i < MAX_FREE ? PW'(NUM_AREGS + i) : '0;
    end else begin
      head <= head_n;
      tail <= tail_n;
      retire_head <= retire_head + ptr_t'(bus.retire_alloc_cnt);
      if (ovf_set) ovf_q <= 1'b1;
      if (bus.free_valid[0]) mem[tail[PW-1:0]] <= bus.free_preg[0];
      if (bus.free_valid[1]) mem[tail1[PW-1:0]] <= bus.free_preg[1];
    end
  end
endmodule

// File: tb/tb_preg_free_list.sv
// tb_preg_free_list: directed self-checking bench for preg_free_list
module tb_preg_free_list;
  import preg_free_list_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  preg_t q[$];
  preg_free_list_if bus ();
  preg_free_list dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [1:0] req, input logic [1:0] fv, input preg_t fp0, input preg_t fp1,
                       input logic [1:0] rac, input logic fl);
    bus.alloc_req = req;
    bus.free_valid = fv;
    bus.free_preg[0] = fp0;
    bus.free_preg[1] = fp1;
    bus.retire_alloc_cnt = rac;
    bus.flush = fl;
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    preg_t v0, v1;
    drive(2'b00, 2'b00, '0, '0, 2'd0, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    cyc();
    chk("rst_preg0", bus.alloc_preg[0], 32);
    chk("rst_preg1", bus.alloc_preg[1], 33);
    chk("rst_empty", bus.alloc_empty, 0);
    chk("rst_count", bus.free_count, 32);
    chk("rst_ovf", bus.overflow_err, 0);
    for (int k = 0; k < 3; k++) begin
      chk("dual_preg0", bus.alloc_preg[0], 32 + 2 * k);
      chk("dual_preg1", bus.alloc_preg[1], 33 + 2 * k);
      drive(2'b11, 2'b00, '0, '0, 2'd0, 1'b0);
      cyc();
    end
    drive(2'b00, 2'b00, '0, '0, 2'd0, 1'b0);
    chk("dual_count", bus.free_count, 26);
    drive(2'b11, 2'b00, '0, '0, 2'd0, 1'b0);
    repeat (12) cyc();
    drive(2'b01, 2'b00, '0, '0, 2'd0, 1'b0);
    cyc();
    chk("one_count", bus.free_count, 1);
    chk("one_empty", bus.alloc_empty, 2);
    chk("one_preg0", bus.alloc_preg[0], 63);
    drive(2'b11, 2'b00, '0, '0, 2'd0, 1'b0);
    cyc();
    chk("zero_count", bus.free_count, 0);
    chk("zero_empty", bus.alloc_empty, 3);
    cyc();
    chk("zero_hold_count", bus.free_count, 0);
    chk("zero_hold_empty", bus.alloc_empty, 3);
    drive(2'b01, 2'b01, 6'd5, '0, 2'd0, 1'b0);
    cyc();
    drive(2'b00, 2'b00, '0, '0, 2'd0, 1'b0);
    chk("byp_count", bus.free_count, 1);
    chk("byp_preg0", bus.alloc_preg[0], 5);
    chk("byp_empty", bus.alloc_empty, 2);
    drive(2'b00, 2'b10, '0, 6'd9, 2'd0, 1'b0);
    cyc();
    drive(2'b00, 2'b00, '0, '0, 2'd0, 1'b0);
    chk("port1_count", bus.free_count, 2);
    chk("port1_preg1", bus.alloc_preg[1], 9);
    drive(2'b10, 2'b00, '0, '0, 2'd0, 1'b0);
    cyc();
    drive(2'b00, 2'b00, '0, '0, 2'd0, 1'b0);
    chk("slot1_alone_count", bus.free_count, 2);
    chk("slot1_alone_preg0", bus.alloc_preg[0], 5);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_count", bus.free_count, 32);
    chk("async_rst_preg0", bus.alloc_preg[0], 32);
    #2 rst = 1'b1;
    cyc();
    drive(2'b11, 2'b00, '0, '0, 2'd2, 1'b0);
    cyc();
    drive(2'b11, 2'b00, '0, '0, 2'd0, 1'b0);
    cyc();
    cyc();
    drive(2'b11, 2'b00, '0, '0, 2'd1, 1'b1);
    cyc();
    drive(2'b00, 2'b00, '0, '0, 2'd0, 1'b0);
    chk("flush_preg0", bus.alloc_preg[0], 35);
    chk("flush_preg1", bus.alloc_preg[1], 36);
    chk("flush_count", bus.free_count, 29);
    drive(2'b11, 2'b00, '0, '0, 2'd0, 1'b0);
    cyc();
    drive(2'b00, 2'b01, 6'd40, '0, 2'd0, 1'b1);
    cyc();
    drive(2'b00, 2'b00, '0, '0, 2'd0, 1'b0);
    chk("flush2_preg0", bus.alloc_preg[0], 35);
    chk("flush2_count", bus.free_count, 30);
    rst = 1'b0;
    #2 rst = 1'b1;
    cyc();
    for (int i = 32; i < 64; i++) q.push_back(preg_t'(i));
    for (int i = 0; i < 100; i++) begin
      chk("wrap_preg0", bus.alloc_preg[0], q[0]);
      chk("wrap_preg1", bus.alloc_preg[1], q[1]);
      void'(q.pop_front());
      void'(q.pop_front());
      v0 = preg_t'(i * 7 + 3);
      v1 = preg_t'(i * 11 + 5);
      q.push_back(v0);
      q.push_back(v1);
      drive(2'b11, 2'b11, v0, v1, 2'd0, 1'b0);
      cyc();
    end
    drive(2'b00, 2'b00, '0, '0, 2'd0, 1'b0);
    chk("wrap_count", bus.free_count, 32);
    chk("wrap_ovf", bus.overflow_err, 0);
    chk("wrap_tail_preg0", bus.alloc_preg[0], q[0]);
    drive(2'b00, 2'b01, 6'd1, '0, 2'd0, 1'b0);
    cyc();
    drive(2'b00, 2'b00, '0, '0, 2'd0, 1'b0);
    chk("ovf_set", bus.overflow_err, 1);
    chk("ovf_count", bus.free_count, 33);
    cyc();
    chk("ovf_sticky", bus.overflow_err, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
